// File: rtl/thiele_isa_pkg.sv
// Thiele simple-ISA definitions shared by the exec sequencer and its mu ledger:
// opcodes, per-opcode mu costs, sequencer state encoding and instruction field slicing.
package thiele_isa_pkg;

  localparam logic [7:0] OPCODE_PNEW     = 8'h00;
  localparam logic [7:0] OPCODE_XOR_LOAD = 8'h0A;
  localparam logic [7:0] OPCODE_XOR_ADD  = 8'h0B;
  localparam logic [7:0] OPCODE_XOR_SWAP = 8'h0C;
  localparam logic [7:0] OPCODE_EMIT     = 8'h0E;
  localparam logic [7:0] OPCODE_HALT     = 8'hFF;

  localparam logic [7:0] MU_COST_PNEW     = 8'd1;
  localparam logic [7:0] MU_COST_XOR_LOAD = 8'd1;
  localparam logic [7:0] MU_COST_XOR_ADD  = 8'd1;
  localparam logic [7:0] MU_COST_XOR_SWAP = 8'd3;
  localparam logic [7:0] MU_COST_EMIT     = 8'd0;
  localparam logic [7:0] MU_COST_HALT     = 8'd1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StDispatch,
    StWait,
    StCommit,
    StHalted,
    StTimeout
  } seq_state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] rsvd;
  } instr_t;

  function automatic instr_t slice_instr(input logic [31:0] word);
    instr_t f;
    f.opcode = word[31:24];
    f.a      = word[23:16];
    f.b      = word[15:8];
    f.rsvd   = word[7:0];
    return f;
  endfunction

  // Opcodes handed to the execution unit; everything else but HALT is undefined.
  function automatic logic is_dispatch_op(input logic [7:0] op);
    return (op == OPCODE_PNEW) || (op == OPCODE_XOR_LOAD) || (op == OPCODE_XOR_ADD) ||
           (op == OPCODE_XOR_SWAP) || (op == OPCODE_EMIT);
  endfunction

  function automatic logic [7:0] exec_cost(input logic [7:0] op);
    logic [7:0] c;
    c = '0;
    case (op)
      OPCODE_XOR_LOAD: c = MU_COST_XOR_LOAD;
      OPCODE_XOR_ADD:  c = MU_COST_XOR_ADD;
      OPCODE_XOR_SWAP: c = MU_COST_XOR_SWAP;
      OPCODE_EMIT:     c = MU_COST_EMIT;
      default:         c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/thiele_mu_ledger.sv
// mu ledger: discovery/execution cost counters, their registered sum and the admitted
// module count, all advanced by single-cycle commit strobes from the sequencer.
module thiele_mu_ledger
  import thiele_isa_pkg::*;
#(
  parameter int unsigned MU_W        = 64,
  parameter int unsigned MAX_MODULES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            pnew,
  input  logic            exec_en,
  input  logic [7:0]      exec_amt,
  output logic [MU_W-1:0] mu_discovery,
  output logic [MU_W-1:0] mu_execution,
  output logic [MU_W-1:0] mu_total,
  output logic [31:0]     num_modules
);

  logic [MU_W-1:0] disc_q, disc_d;
  logic [MU_W-1:0] exec_q, exec_d;
  logic [MU_W-1:0] total_q;
  logic [31:0]     mods_q, mods_d;

  always_comb begin
    disc_d = disc_q;
    exec_d = exec_q;
    mods_d = mods_q;
    if (clear) begin
      disc_d = '0;
      exec_d = '0;
      mods_d = '0;
    end else begin
      // PNEW beyond capacity is free and not counted.
      if (pnew && (mods_q < MAX_MODULES)) begin
        disc_d = disc_q + MU_W'(MU_COST_PNEW);
        mods_d = mods_q + 32'd1;
      end
      if (exec_en) begin
        exec_d = exec_q + MU_W'(exec_amt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_q  <= '0;
      exec_q  <= '0;
      total_q <= '0;
      mods_q  <= '0;
    end else begin
      disc_q  <= disc_d;
      exec_q  <= exec_d;
      total_q <= disc_d + exec_d;
      mods_q  <= mods_d;
    end
  end

  assign mu_discovery = disc_q;
  assign mu_execution = exec_q;
  assign mu_total     = total_q;
  assign num_modules  = mods_q;

endmodule

// File: rtl/thiele_exec_sequencer.sv
// Fetch/decode/dispatch controller for the Thiele simple-ISA path: PC, step count, FSM and
// fetch latch, with mu accounting in thiele_mu_ledger. Define THIELE_WATCHDOG_EN for the watchdog.
module thiele_exec_sequencer
  import thiele_isa_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned MU_W        = 64,
  parameter int unsigned MAX_MODULES = 64,
  parameter int unsigned WDOG_LIMIT  = 10000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            exec_valid,
  input  logic            exec_ready,
  output logic [7:0]      exec_opcode,
  output logic [7:0]      exec_a,
  output logic [7:0]      exec_b,
  input  logic            exec_done,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     step_count,
  output logic [31:0]     num_modules,
  output logic [MU_W-1:0] mu_discovery,
  output logic [MU_W-1:0] mu_execution,
  output logic [MU_W-1:0] mu_total,
  output logic            busy,
  output logic            halted,
  output logic            timeout,
  output logic            unknown_seen
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     step_q, step_d;
  instr_t          instr_q, instr_d;
  logic            unk_q, unk_d;

  logic            start_ok;
  logic            clear;
  logic            pnew;
  logic            exec_en;
  logic [7:0]      exec_amt;
  logic            wdog_fire;
  logic            halt_decode;

  assign busy        = !(state_q inside {StIdle, StHalted, StTimeout});
  assign start_ok    = start && !busy;
  assign halt_decode = (state_q == StDecode) && (instr_q.opcode == OPCODE_HALT);

`ifdef THIELE_WATCHDOG_EN
  logic [31:0] wdog_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (start_ok) begin
      wdog_q <= '0;
    end else if (busy) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end

  // Fires in the busy cycle whose increment makes the count reach the limit.
  assign wdog_fire = busy && ((wdog_q + 32'd1) >= WDOG_LIMIT);
  assign timeout   = (state_q == StTimeout);
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = (WDOG_LIMIT != 0);
  assign wdog_fire         = 1'b0;
  assign timeout           = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    step_d   = step_q;
    instr_d  = instr_q;
    unk_d    = unk_q;
    clear    = 1'b0;
    pnew     = 1'b0;
    exec_en  = 1'b0;
    exec_amt = '0;

    case (state_q)
      StIdle, StHalted, StTimeout: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          step_d  = '0;
          unk_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      StFetch: begin
        if (imem_valid) begin
          instr_d = slice_instr(imem_rdata);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (instr_q.opcode == OPCODE_HALT) begin
          state_d  = StHalted;
          exec_en  = 1'b1;
          exec_amt = MU_COST_HALT;
        end else if (is_dispatch_op(instr_q.opcode)) begin
          state_d = StDispatch;
        end else begin
          state_d = StCommit;
        end
      end
      StDispatch: begin
        if (exec_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (exec_done) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StFetch;
        pc_d    = pc_q + PC_W'(1);
        step_d  = step_q + 32'd1;
        if (instr_q.opcode == OPCODE_PNEW) begin
          pnew = 1'b1;
        end else if (is_dispatch_op(instr_q.opcode)) begin
          exec_en  = 1'b1;
          exec_amt = exec_cost(instr_q.opcode);
        end else begin
          unk_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog freezes everything, except that a HALT decoding this cycle still completes.
    if (wdog_fire && !halt_decode) begin
      state_d = StTimeout;
      pc_d    = pc_q;
      step_d  = step_q;
      instr_d = instr_q;
      unk_d   = unk_q;
      pnew    = 1'b0;
      exec_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      step_q  <= '0;
      instr_q <= '0;
      unk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      step_q  <= step_d;
      instr_q <= instr_d;
      unk_q   <= unk_d;
    end
  end

  thiele_mu_ledger #(
    .MU_W        (MU_W),
    .MAX_MODULES (MAX_MODULES)
  ) u_ledger (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .pnew         (pnew),
    .exec_en      (exec_en),
    .exec_amt     (exec_amt),
    .mu_discovery (mu_discovery),
    .mu_execution (mu_execution),
    .mu_total     (mu_total),
    .num_modules  (num_modules)
  );

  logic unused_rsvd;
  assign unused_rsvd = ^instr_q.rsvd;

  assign imem_req     = (state_q == StFetch);
  assign imem_addr    = pc_q;
  assign exec_valid   = (state_q == StDispatch);
  assign exec_opcode  = instr_q.opcode;
  assign exec_a       = instr_q.a;
  assign exec_b       = instr_q.b;
  assign pc           = pc_q;
  assign step_count   = step_q;
  assign halted       = (state_q == StHalted);
  assign unknown_seen = unk_q;

endmodule

// File: tb/tb_thiele_exec_sequencer.sv
// Self-checking bench for thiele_exec_sequencer: an ISA-level interpreter predicts fetch order,
// dispatches and final counters; one negedge process models imem/exec and checks every cycle.
module tb_thiele_exec_sequencer;

  localparam int unsigned PcW       = 8;
  localparam int unsigned MuW       = 64;
  localparam int unsigned MaxMod    = 64;
  localparam int unsigned WdogLimit = 50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           imem_req;
  logic [PcW-1:0] imem_addr;
  logic [31:0]    imem_rdata;
  logic           imem_valid;
  logic           exec_valid;
  logic           exec_ready;
  logic [7:0]     exec_opcode, exec_a, exec_b;
  logic           exec_done;
  logic [PcW-1:0] pc;
  logic [31:0]    step_count, num_modules;
  logic [MuW-1:0] mu_discovery, mu_execution, mu_total;
  logic           busy, halted, timeout, unknown_seen;

  always #5 clk = ~clk;

  thiele_exec_sequencer #(
    .PC_W        (PcW),
    .MU_W        (MuW),
    .MAX_MODULES (MaxMod),
    .WDOG_LIMIT  (WdogLimit)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .exec_valid   (exec_valid),
    .exec_ready   (exec_ready),
    .exec_opcode  (exec_opcode),
    .exec_a       (exec_a),
    .exec_b       (exec_b),
    .exec_done    (exec_done),
    .pc           (pc),
    .step_count   (step_count),
    .num_modules  (num_modules),
    .mu_discovery (mu_discovery),
    .mu_execution (mu_execution),
    .mu_total     (mu_total),
    .busy         (busy),
    .halted       (halted),
    .timeout      (timeout),
    .unknown_seen (unknown_seen)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] imem [256];
  logic [31:0] prog [$];
  logic [7:0]  exp_fetch [$];
  logic [31:0] exp_disp [$];

  // Responder configuration (written by the main flow only).
  bit rand_mode = 0, no_done = 0, spur = 0;
  int fetch_lat = 0, ready_lat = 0, done_lat = 0;

  // Responder/compare state (written by the compare process only).
  bit          in_fetch = 0, in_disp = 0, pend_done = 0;
  int          fetch_cnt = 0, ready_cnt = 0, done_cnt = 0;
  int          disp_cnt = 0, ev_seen = 0;
  logic [23:0] held, fields;

  // Model results.
  logic [31:0] m_step, m_mods;
  logic [7:0]  m_pc;
  logic [63:0] m_disc, m_exec;
  bit          m_unk;
  int          m_ndisp;
  int          run_disp, run_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int fixed);
    return rand_mode ? int'($urandom_range(0, 3)) : fixed;
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFF00_0000;
    foreach (prog[i]) imem[i] = prog[i];
  endtask

  // ISA interpreter: walk the program from address 0 until HALT.
  task automatic build_model();
    logic [7:0] p;
    logic [7:0] op;
    p = 8'd0; m_step = 0; m_mods = 0; m_disc = 0; m_exec = 0; m_unk = 0; m_ndisp = 0;
    exp_fetch.delete();
    exp_disp.delete();
    for (int n = 0; n < 4096; n++) begin
      exp_fetch.push_back(p);
      op = imem[p][31:24];
      if (op == 8'hFF) begin
        m_exec += 1;
        break;
      end
      if (op inside {8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0E}) begin
        exp_disp.push_back(imem[p]);
        m_ndisp++;
      end else begin
        m_unk = 1;
      end
      if (op == 8'h00 && m_mods < MaxMod) begin
        m_mods += 1;
        m_disc += 1;
      end
      if (op == 8'h0A || op == 8'h0B) m_exec += 1;
      if (op == 8'h0C) m_exec += 3;
      m_step += 1;
      p = p + 8'd1;
    end
    m_pc = p;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_prog(input string name, input int budget);
    int d0, e0, cyc;
    load_prog();
    build_model();
    d0 = disp_cnt;
    e0 = ev_seen;
    pulse_start();
    chk({name, ":first_fetch"}, {imem_req, imem_addr}, {1'b1, 8'h00});
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    run_disp = disp_cnt - d0;
    run_ev   = ev_seen - e0;
    chk({name, ":halted"}, halted, 1);
    chk({name, ":busy"}, busy, 0);
    chk({name, ":pc"}, pc, m_pc);
    chk({name, ":step_count"}, step_count, m_step);
    chk({name, ":num_modules"}, num_modules, m_mods);
    chk({name, ":mu_discovery"}, mu_discovery, m_disc);
    chk({name, ":mu_execution"}, mu_execution, m_exec);
    chk({name, ":mu_total"}, mu_total, m_disc + m_exec);
    chk({name, ":unknown_seen"}, unknown_seen, m_unk);
    chk({name, ":dispatches"}, run_disp, m_ndisp);
    chk({name, ":fetches_left"}, exp_fetch.size(), 0);
    chk({name, ":dispatches_left"}, exp_disp.size(), 0);
  endtask

  task automatic set_fixed(input int f, input int r, input int d);
    rand_mode = 0; spur = 0; no_done = 0;
    fetch_lat = f; ready_lat = r; done_lat = d;
  endtask

  // Compare process: checks outputs, then drives imem/exec responses for the next edge.
  initial begin
    imem_valid = 1'b0; imem_rdata = '0; exec_ready = 1'b0; exec_done = 1'b0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      exec_ready = 1'b0;
      exec_done  = 1'b0;
      if (!rst_n) begin
        in_fetch = 0; in_disp = 0; pend_done = 0;
        continue;
      end
      if (timeout) pend_done = 0;
      chk("mu_total_sum", mu_total, mu_discovery + mu_execution);
      if (pend_done && !no_done) chk("wait_quiet", {exec_valid, imem_req, busy}, 3'b001);
      if (exec_valid) ev_seen++;
      if (pend_done && !no_done) begin
        if (done_cnt == 0) begin
          exec_done = 1'b1;
          pend_done = 0;
        end else begin
          done_cnt--;
        end
      end
      if (imem_req) begin
        if (!in_fetch) begin
          in_fetch  = 1;
          fetch_cnt = pick(fetch_lat);
        end
        if (fetch_cnt == 0) begin
          in_fetch   = 0;
          imem_valid = 1'b1;
          imem_rdata = imem[imem_addr];
          chk("fetch_expected", exp_fetch.size() != 0, 1);
          if (exp_fetch.size() != 0) chk("fetch_addr", imem_addr, exp_fetch.pop_front());
        end else begin
          fetch_cnt--;
        end
      end
      if (exec_valid) begin
        fields = {exec_opcode, exec_a, exec_b};
        if (!in_disp) begin
          in_disp   = 1;
          ready_cnt = pick(ready_lat);
          held      = fields;
        end else begin
          chk("exec_stable", fields, held);
        end
        if (ready_cnt == 0) begin
          exec_ready = 1'b1;
          in_disp    = 0;
          disp_cnt++;
          pend_done  = 1;
          done_cnt   = pick(done_lat);
          chk("disp_expected", exp_disp.size() != 0, 1);
          if (exp_disp.size() != 0) begin
            logic [31:0] w;
            w = exp_disp.pop_front();
            chk("disp_fields", fields, w[31:8]);
          end
          // Done coinciding with acceptance must be ignored by the sequencer.
          if (spur && $urandom_range(0, 1) == 1) exec_done = 1'b1;
        end else begin
          ready_cnt--;
        end
      end
    end
  end

  initial begin
    int d0, cyc, len, sel;
    logic [7:0] op;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {imem_req, exec_valid, busy, halted, timeout, unknown_seen}, 0);
    chk("reset_counts", {step_count, num_modules}, 0);
    chk("reset_mu", mu_total | mu_discovery | mu_execution, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, halted, pc}, 0);

    // Basic program, single-cycle responders; literal values pin the model.
    set_fixed(0, 0, 0);
    prog = '{32'h0005_0000, 32'h0A00_0700, 32'h0B01_0000, 32'hFF00_0000};
    run_prog("basic", 200);
    chk("basic:lit_pc", pc, 3);
    chk("basic:lit_step", step_count, 3);
    chk("basic:lit_disc", mu_discovery, 1);
    chk("basic:lit_exec", mu_execution, 3);
    chk("basic:lit_total", mu_total, 4);

`ifdef THIELE_WATCHDOG_EN
    // Watchdog: the op is accepted but never completes.
    set_fixed(0, 0, 0);
    no_done = 1;
    prog = '{32'h0A00_0000, 32'hFF00_0000};
    load_prog();
    build_model();
    pulse_start();
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 50) chk("wdog:before_limit", timeout, 0);
    end
    chk("wdog:timeout", timeout, 1);
    chk("wdog:not_halted", {halted, busy, exec_valid, imem_req}, 0);
    chk("wdog:frozen", {step_count, mu_total[31:0]}, 0);
    no_done = 0;
    prog = '{32'h0005_0000, 32'h0A00_0700, 32'h0B01_0000, 32'hFF00_0000};
    run_prog("wdog_restart", 200);
    chk("wdog_restart:timeout_clear", timeout, 0);
`else
    // Slow handshakes: ready after 5 cycles, done 3 cycles later.
    set_fixed(0, 5, 3);
    prog = '{32'h0C01_0200, 32'hFF00_0000};
    run_prog("swap_slow", 200);
    chk("swap_slow:lit_exec", mu_execution, 4);
    chk("swap_slow:lit_disp", run_disp, 1);

    // PNEW capacity.
    set_fixed(0, 0, 0);
    prog.delete();
    for (int i = 0; i < 65; i++) prog.push_back(32'h0000_0000 | (32'(i) << 16));
    prog.push_back(32'hFF00_0000);
    run_prog("pnew_cap", 2000);
    chk("pnew_cap:lit_mods", num_modules, 64);
    chk("pnew_cap:lit_disc", mu_discovery, 64);
    chk("pnew_cap:lit_step", step_count, 65);

    // Undefined opcode.
    set_fixed(1, 0, 0);
    prog = '{32'h7A12_3400, 32'hFF00_0000};
    run_prog("undef", 200);
    chk("undef:lit_no_valid", run_ev, 0);
    chk("undef:lit_unknown", unknown_seen, 1);
    chk("undef:lit_step", step_count, 1);
    chk("undef:lit_total", mu_total, 1);

    // Asynchronous reset in WAIT of the second op, then restart from address 0.
    set_fixed(0, 0, 0);
    prog = '{32'h0A01_0000, 32'h0B02_0300, 32'hFF00_0000};
    load_prog();
    build_model();
    d0 = disp_cnt;
    pulse_start();
    cyc = 0;
    while (disp_cnt < d0 + 1 && cyc < 100) begin @(negedge clk); cyc++; end
    done_lat = 30;
    while (disp_cnt < d0 + 2 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rst:second_dispatch", disp_cnt - d0, 2);
    @(negedge clk);
    chk("rst:in_wait", {busy, exec_valid, pc}, {1'b1, 1'b0, 8'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("rst:ctrl", {imem_req, exec_valid, busy, halted, timeout, unknown_seen}, 0);
    chk("rst:pc", {imem_addr, pc}, 0);
    chk("rst:fields", {exec_opcode, exec_a, exec_b}, 0);
    chk("rst:counts", {step_count, num_modules}, 0);
    chk("rst:mu", mu_total | mu_discovery | mu_execution, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_fixed(0, 0, 0);
    run_prog("rst_restart", 200);

    // Randomised programs with random handshake latencies.
    for (int r = 0; r < 15; r++) begin
      rand_mode = 1; spur = 1; no_done = 0;
      prog.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: op = 8'h00;
          1: op = 8'h0A;
          2: op = 8'h0B;
          3: op = 8'h0C;
          4: op = 8'h0E;
          default: begin
            do op = 8'($urandom_range(1, 254));
            while (op inside {8'h0A, 8'h0B, 8'h0C, 8'h0E});
          end
        endcase
        prog.push_back({op, 8'($urandom), 8'($urandom), 8'($urandom)});
      end
      prog.push_back(32'hFF00_0000);
      run_prog($sformatf("rand%0d", r), 1000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
